// File: rtl/sort_sequencer_pkg.sv
// Shared sizes and the state encoding for the sort sequencer.
package sort_seq_pkg;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {LOAD, START, WAIT, READ, PRESENT} state_t;
endpackage

// File: rtl/sort_sequencer_if.sv
// Load stream, result stream and sorter host port of the sort sequencer.
interface sort_sequencer_if;
  import sort_seq_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              s_start;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_datain;
  logic [DATA_W-1:0] s_dataout;
  logic              s_ready;

  modport master (
    input  in_valid, in_data, out_ready, s_dataout, s_ready,
    output in_ready, out_valid, out_data, out_last, busy,
           s_start, s_wr, s_addr, s_datain
  );
  modport slave (
    output in_valid, in_data, out_ready, s_dataout, s_ready,
    input  in_ready, out_valid, out_data, out_last, busy,
           s_start, s_wr, s_addr, s_datain
  );
endinterface

// File: rtl/sort_sequencer.sv
// Loads 8 bytes into an external sorter, starts it, then streams the sorted bytes out.
// SORT_SEQ_DESC_EN: read the sorter RAM from address 7 down to 0 (descending results).
module sort_sequencer
  import sort_seq_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  sort_sequencer_if.master bus
);
  state_t            state;
  logic [ADDR_W-1:0] wcnt, rcnt, raddr;
  logic [DATA_W-1:0] hold;
  logic              fresh;
  logic              accept;

  assign accept = (state == LOAD) && bus.in_valid && bus.s_ready;

`ifdef SORT_SEQ_DESC_EN
  assign raddr = ADDR_W'(DEPTH-1) - rcnt;
`else
  assign raddr = rcnt;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= LOAD;
      wcnt  <= '0;
      rcnt  <= '0;
      hold  <= '0;
      fresh <= 1'b0;
    end else begin
      case (state)
        LOAD: if (accept) begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == ADDR_W'(DEPTH-1)) state <= START;
        end
        START: state <= WAIT;
        WAIT:  if (bus.s_ready) state <= READ;
        READ: begin
          state <= PRESENT;
          fresh <= 1'b1;
        end
        PRESENT: begin
          // RAM output is only valid from the first PRESENT cycle; latch it there
          if (fresh) begin
            hold  <= bus.s_dataout;
            fresh <= 1'b0;
          end
          if (bus.out_ready) begin
            if (rcnt == ADDR_W'(DEPTH-1)) begin
              rcnt  <= '0;
              state <= LOAD;
            end else begin
              rcnt  <= rcnt + 1'b1;
              state <= READ;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state == LOAD) && bus.s_ready;
  assign bus.s_wr      = accept;
  assign bus.s_datain  = accept ? bus.in_data : '0;
  assign bus.s_start   = (state == START);
  assign bus.s_addr    = (state == LOAD) ? wcnt :
                         (state == READ || state == PRESENT) ? raddr : '0;
  assign bus.out_valid = (state == PRESENT);
  assign bus.out_data  = (state == PRESENT && fresh) ? bus.s_dataout : hold;
  assign bus.out_last  = bus.out_valid && (rcnt == ADDR_W'(DEPTH-1));
  assign bus.busy      = (state != LOAD);
endmodule
